// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
// FSM state encoding and iteration counter width.
package div_pkg;

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } div_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;
`endif

  // wide enough to count WIDTH steps for WIDTH up to 32
  localparam int CNT_W = 6;

endpackage

// File: rtl/div_step.sv
// One restoring iteration: shift in next dividend bit,
// trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;
  logic             ok;

  assign sh      = {rem_in, q_in[WIDTH-1]};
  // top bit of diff acts as the borrow of the trial subtract
  assign diff    = sh - {2'b00, d};
  assign ok      = ~diff[WIDTH+1];
  assign rem_out = ok ? diff[WIDTH:0] : sh[WIDTH:0];
  assign q_out   = {q_in[WIDTH-2:0], ok};

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's-complement operands.
module restoring_divider
  import div_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] ZERO_Q = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_t       state_q;
  div_state_t       state_d;
  logic             accept;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] d_r;

`ifdef DIV_SIGNED_EN
  logic a_neg;
  logic q_neg;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem_r),
    .q_in   (q_r),
    .d      (d_r),
    .rem_out(rem_nx),
    .q_out  (q_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          accept  = 1'b1;
          state_d = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == LAST) begin
          last = 1'b1;
`ifdef DIV_SIGNED_EN
          state_d = FIXUP;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      FIXUP: state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef DIV_SIGNED_EN
  assign busy = (state_q == CALC) || (state_q == FIXUP);
`else
  assign busy = (state_q == CALC);
`endif
  assign done = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem_r     <= '0;
      q_r       <= '0;
      d_r       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
      a_neg     <= 1'b0;
      q_neg     <= 1'b0;
`endif
    end else if (accept) begin
      cnt   <= '0;
      rem_r <= '0;
`ifdef DIV_SIGNED_EN
      // iterate on magnitudes, signs are restored in FIXUP
      a_neg <= dividend[WIDTH-1];
      q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      q_r   <= dividend[WIDTH-1] ? -dividend : dividend;
      d_r   <= divisor[WIDTH-1] ? -divisor : divisor;
`else
      q_r   <= dividend;
      d_r   <= divisor;
`endif
      div_zero <= (divisor == '0);
      if (divisor == '0) begin
        quotient  <= ZERO_Q;
        remainder <= dividend;
      end
    end else if (state_q == CALC) begin
      cnt   <= cnt + 1'b1;
      rem_r <= rem_nx;
      q_r   <= q_nx;
`ifndef DIV_SIGNED_EN
      if (last) begin
        quotient  <= q_nx;
        remainder <= rem_nx[WIDTH-1:0];
      end
`endif
    end
`ifdef DIV_SIGNED_EN
    else if (state_q == FIXUP) begin
      quotient  <= q_neg ? -q_r : q_r;
      remainder <= a_neg ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
    end
`endif
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed-vector bench for restoring_divider, WIDTH=16.
// Latency expectations follow the DIV_SIGNED_EN build choice.
module tb_restoring_divider;

  localparam int W = 16;
`ifdef DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int vectors = 0;
  int miscompares = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  // drive start for one edge; returns #1 after the accepting edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // n counts cycles since the accepting edge (1 right after it)
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    vectors++;
    if (quotient !== 16'h0 || remainder !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_qr: got %h/%h want 0/0", quotient, remainder);
    end
    vectors++;
    if (div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dz: got %b want 0", div_zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int n;
    start_op(16'd100, 16'd7);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy: got busy=%b done=%b want 1/0", busy, done);
    end
    wait_done(n);
    vectors++;
    if (n !== LAT) begin
      miscompares++;
      $display("FAIL basic_lat: got %0d want %0d", n, LAT);
    end
    vectors++;
    if (quotient !== 16'd14 || remainder !== 16'd2) begin
      miscompares++;
      $display("FAIL basic_qr: got %0d r%0d want 14 r2", quotient, remainder);
    end
    vectors++;
    if (div_zero !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_flags: got dz=%b busy=%b want 0/0", div_zero, busy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || quotient !== 16'd14 || remainder !== 16'd2) begin
      miscompares++;
      $display("FAIL basic_hold: got done=%b %0d r%0d want 0 14 r2",
               done, quotient, remainder);
    end
  endtask

  task automatic test_div_zero;
    int n;
    start_op(16'd5, 16'd0);
    wait_done(n);
    vectors++;
    if (n !== 1) begin
      miscompares++;
      $display("FAIL dz_lat: got %0d want 1", n);
    end
    vectors++;
    if (quotient !== 16'hFFFF || remainder !== 16'd5) begin
      miscompares++;
      $display("FAIL dz_qr: got %h r%h want ffff r0005", quotient, remainder);
    end
    vectors++;
    if (div_zero !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL dz_flags: got dz=%b busy=%b want 1/0", div_zero, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int n;
    start_op(16'hFFFF, 16'd1);
    wait_done(n);
    vectors++;
    if (quotient !== 16'hFFFF || remainder !== 16'd0) begin
      miscompares++;
      $display("FAIL b2b_first: got %h r%h want ffff r0000", quotient, remainder);
    end
    start_op(16'd3, 16'd9);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap: got busy=%b done=%b want 1/0", busy, done);
    end
    wait_done(n);
    vectors++;
    if (n !== LAT) begin
      miscompares++;
      $display("FAIL b2b_lat: got %0d want %0d", n, LAT);
    end
    vectors++;
    if (quotient !== 16'd0 || remainder !== 16'd3) begin
      miscompares++;
      $display("FAIL b2b_second: got %0d r%0d want 0 r3", quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int n;
    start_op(16'd1000, 16'd3);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst_flags: got busy=%b done=%b dz=%b want 0",
               busy, done, div_zero);
    end
    vectors++;
    if (quotient !== 16'd0 || remainder !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_rst_qr: got %h/%h want 0/0", quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    start_op(16'd1000, 16'd3);
    wait_done(n);
    vectors++;
    if (n !== LAT || quotient !== 16'd333 || remainder !== 16'd1) begin
      miscompares++;
      $display("FAIL mid_rst_rerun: got lat=%0d %0d r%0d want %0d 333 r1",
               n, quotient, remainder, LAT);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_busy;
    int n;
    start_op(16'd1000, 16'd3);
    for (int i = 0; i < 4; i++) begin
      dividend = 16'd50 + 16'(i);
      divisor  = 16'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ign_busy: got %b want 1", busy);
    end
    wait_done(n);
    vectors++;
    if (n + 4 !== LAT) begin
      miscompares++;
      $display("FAIL ign_lat: got %0d want %0d", n + 4, LAT);
    end
    vectors++;
    if (quotient !== 16'd333 || remainder !== 16'd1) begin
      miscompares++;
      $display("FAIL ign_qr: got %0d r%0d want 333 r1", quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_less_than;
    int n;
    start_op(16'd7, 16'd200);
    wait_done(n);
    vectors++;
    if (n !== LAT || quotient !== 16'd0 || remainder !== 16'd7) begin
      miscompares++;
      $display("FAIL less: got lat=%0d %0d r%0d want %0d 0 r7",
               n, quotient, remainder, LAT);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed;
    int n;
    start_op(16'hFFF9, 16'd2);
    wait_done(n);
    vectors++;
    if (n !== 18 || quotient !== 16'hFFFD || remainder !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL signed_neg7_2: got lat=%0d %h r%h want 18 fffd rffff",
               n, quotient, remainder);
    end
    @(posedge clk);
    #1;
    start_op(16'h8000, 16'hFFFF);
    wait_done(n);
    vectors++;
    if (quotient !== 16'h8000 || remainder !== 16'h0 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL signed_wrap: got %h r%h dz=%b want 8000 r0000 0",
               quotient, remainder, div_zero);
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_ignore_busy();
    test_less_than();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal 4..32).
REQ-002 SHALL have parameter ZERO_Q, default all-ones, quotient value returned on divide-by-zero.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  request; sampled only when accepting (IDLE or DONE).
REQ-006 SHALL have port dividend  input  WIDTH  numerator, captured on accepted start.
REQ-007 SHALL have port divisor  input  WIDTH  denominator, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-010 SHALL have port quotient  output  WIDTH  result quotient.
REQ-011 SHALL have port remainder  output  WIDTH  result remainder.
REQ-012 SHALL have port div_zero  output  1  set with done when the captured divisor was 0.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, (FIXUP when signed), DONE.
REQ-014 SHALL accept start only in IDLE or DONE: capture operands, clear counter, go to CALC (or DONE if divisor==0).
REQ-015 SHALL ignore start while busy; captured operands remain unchanged.
REQ-016 SHALL perform one restoring shift-subtract step per CALC cycle, MSB first, WIDTH steps total.
REQ-017 SHALL keep the partial remainder WIDTH+1 bits wide so no step overflows for any unsigned operands.
REQ-018 SHALL assert done exactly WIDTH+1 cycles after the accepting edge (unsigned build).
REQ-019 SHALL, on divisor==0, assert done one cycle after the accepting edge with quotient=ZERO_Q, remainder=dividend, div_zero=1.
REQ-020 SHALL hold quotient, remainder and div_zero stable from done until the next accepted start.
REQ-021 SHALL return from DONE to IDLE after one cycle if start is low; start high in DONE begins a new division back-to-back.
REQ-022 SHALL keep busy high in CALC and FIXUP only; busy and done are never high together.
REQ-023 SHALL produce quotient=0, remainder=dividend when dividend<divisor (no special path; normal latency).

Reset
REQ-024 SHALL, on rst high at any time including mid-CALC, asynchronously force IDLE, busy=0, done=0, div_zero=0, quotient=0, remainder=0, counter=0.
REQ-025 SHALL accept a start on the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL support macro DIV_SIGNED_EN; without it operands are unsigned and FIXUP does not exist.
REQ-027 SHALL, with DIV_SIGNED_EN, treat operands as two's complement: divide magnitudes, then negate in FIXUP; quotient truncates toward zero, remainder takes dividend's sign; done latency becomes WIDTH+2.
REQ-028 SHALL, with DIV_SIGNED_EN, return quotient=most-negative, remainder=0 for most-negative / -1 (wrap, no flag).

Structure
REQ-029 SHALL place the FSM state typedef and step-count width constant in shared package div_pkg.
REQ-030 SHALL implement one iteration as combinational sub-module div_step (shift, trial subtract, restore select), instantiated once.

Verification (WIDTH=16)
REQ-031 SHALL check 100/7 -> done 17 cycles after start, quotient=14, remainder=2, div_zero=0.
REQ-032 SHALL check 5/0 -> done 1 cycle after start, quotient=0xFFFF, remainder=5, div_zero=1.
REQ-033 SHALL check 0xFFFF/1 then start held high in DONE with 3/9 -> first result 0xFFFF r0, second quotient=0 r3, no idle gap.
REQ-034 SHALL check rst pulsed at CALC cycle 8 of 1000/3 -> all outputs 0 immediately; next 1000/3 yields 333 r1.
REQ-035 SHALL check start pulses during busy with changed operands -> ignored, result matches original operands.
REQ-036 SHALL check, with DIV_SIGNED_EN, -7/2 -> quotient=-3, remainder=-1, done after 18 cycles; 0x8000/0xFFFF -> quotient=0x8000, remainder=0.
